// File: rtl/dm_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: op encodings,
// FSM state type, latched command payload and the default memory depth.
package dm_arb_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 3072;

    localparam logic [1:0] OP_WORD = 2'b00;
    localparam logic [1:0] OP_BYTE = 2'b01;
    localparam logic [1:0] OP_HALF = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Command captured from the winning port in IDLE.
    typedef struct packed {
        logic        port;
        logic        we;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

endpackage

// File: rtl/dm_lane_gen.sv
// Byte-lane generator: turns a command's size/address/data into lane enables,
// lane-replicated store data and a legality flag.
//   i_op      : size encoding (word/byte/half, 11 illegal)
//   i_addr    : byte address
//   i_wdata   : right-justified store data
//   o_be_c    : byte-lane enables
//   o_wdata_c : store data replicated across lanes
//   o_err_c   : command is illegal (bad op, misaligned or out of range)
module dm_lane_gen
    import dm_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic [1:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be_c,
    output logic [31:0] o_wdata_c,
    output logic        o_err_c
);

    logic w_out_of_range;

    assign w_out_of_range = ({2'b00, i_addr[31:2]} >= 32'(MEM_WORDS));

    // Lane decode per access size; alignment faults fold into the range check.
    always_comb begin
        o_be_c    = 4'b0000;
        o_wdata_c = i_wdata;
        o_err_c   = w_out_of_range;
        case (i_op)
            OP_WORD: begin
                o_be_c    = 4'b1111;
                o_wdata_c = i_wdata;
                if (i_addr[1:0] != 2'b00) o_err_c = 1'b1;
            end
            OP_HALF: begin
                o_be_c    = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata_c = {2{i_wdata[15:0]}};
                if (i_addr[0]) o_err_c = 1'b1;
            end
            OP_BYTE: begin
                o_be_c    = 4'b0001 << i_addr[1:0];
                o_wdata_c = {4{i_wdata[7:0]}};
            end
            default: o_err_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported word memory.
// One command in flight: IDLE picks a winner, ISSUE drives the memory and
// pulses gnt (plus err when rejected), RESP returns load data.
//   clk, reset                  : clock, synchronous active-high reset
//   pN_req/we/op/addr/wdata     : port N command, held until pN_gnt
//   pN_gnt/err/rvalid/rdata     : port N accept, reject, load-data pulse, load word
//   mem_we/be/addr/wdata        : memory write strobe, lanes, word address, data
//   mem_rdata                   : combinational read of the word at mem_addr
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_op,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_err,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_op,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_err,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      r_state;
    cmd_t        r_cmd;
    logic        r_last;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    logic        w_win;
    cmd_t        w_pick;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_err;
    logic        w_issue;
    logic        w_resp;

    dm_lane_gen #(
        .MEM_WORDS (MEM_WORDS)
    ) u_lane_gen (
        .i_op      (r_cmd.op),
        .i_addr    (r_cmd.addr),
        .i_wdata   (r_cmd.wdata),
        .o_be_c    (w_be),
        .o_wdata_c (w_wdata),
        .o_err_c   (w_err)
    );

    // Port 1 wins when alone, or on a tie when port 0 held the last grant.
    assign w_win  = p1_req & (~p0_req | ~r_last);
    assign w_pick = w_win ? cmd_t'{port: 1'b1, we: p1_we, op: p1_op, addr: p1_addr, wdata: p1_wdata}
                          : cmd_t'{port: 1'b0, we: p0_we, op: p0_op, addr: p0_addr, wdata: p0_wdata};

    // Command FSM; load data is captured on the ISSUE -> RESP edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cmd    <= '0;
            r_last   <= 1'b1;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (p0_req | p1_req) begin
                        r_cmd   <= w_pick;
                        r_last  <= w_win;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_err || r_cmd.we) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RESP;
                        if (r_cmd.port) r_rdata1 <= mem_rdata;
                        else            r_rdata0 <= mem_rdata;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Every output is forced low while reset is high, so a reset landing in
    // ISSUE neither grants nor writes.
    assign w_issue = (r_state == ST_ISSUE) & ~reset;
    assign w_resp  = (r_state == ST_RESP) & ~reset;

    assign p0_gnt    = w_issue & ~r_cmd.port;
    assign p1_gnt    = w_issue &  r_cmd.port;
    assign p0_err    = p0_gnt & w_err;
    assign p1_err    = p1_gnt & w_err;
    assign p0_rvalid = w_resp & ~r_cmd.port;
    assign p1_rvalid = w_resp &  r_cmd.port;
    assign p0_rdata  = reset ? 32'h0 : r_rdata0;
    assign p1_rdata  = reset ? 32'h0 : r_rdata1;

    assign mem_we    = w_issue & r_cmd.we & ~w_err;
    assign mem_be    = w_issue ? w_be : 4'b0000;
    assign mem_addr  = w_issue ? {r_cmd.addr[31:2], 2'b00} : 32'h0;
    assign mem_wdata = w_issue ? w_wdata : 32'h0;

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 3072: number of 32-bit words behind the memory port.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 p0_req  in  1  port 0 request; held with fields stable until p0_gnt.
REQ-005 p0_we  in  1  1 = store, 0 = load.
REQ-006 p0_op  in  2  size: 00 word, 01 byte, 10 half, 11 illegal.
REQ-007 p0_addr  in  32  byte address.
REQ-008 p0_wdata  in  32  store data, right-justified.
REQ-009 p0_gnt  out  1  one-cycle pulse: command accepted.
REQ-010 p0_err  out  1  pulses with p0_gnt when the command is rejected.
REQ-011 p0_rvalid  out  1  one-cycle pulse: load data valid.
REQ-012 p0_rdata  out  32  full memory word of the load.
REQ-013 p1_req, p1_we, p1_op, p1_addr, p1_wdata, p1_gnt, p1_err, p1_rvalid, p1_rdata: port 1, identical widths and meaning to port 0.
REQ-014 mem_we  out  1  memory write strobe; memory commits on posedge clk.
REQ-015 mem_be  out  4  byte-lane enables, bit i = bits [8i+7:8i].
REQ-016 mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_rdata  in  32  combinational read of the word at mem_addr.

Function
REQ-019 FSM states IDLE, ISSUE, RESP; reset state IDLE.
REQ-020 IDLE: if any req, pick a winner, latch its we/op/addr/wdata and port id, go to ISSUE next cycle; else stay in IDLE.
REQ-021 Arbitration round-robin: single request wins; on simultaneous requests the port not granted last wins; the last-grant pointer updates on every grant.
REQ-022 ISSUE (exactly one cycle): mem_addr/mem_be/mem_wdata driven from the latch, winner's gnt pulses, mem_we = latched we AND no error.
REQ-023 ISSUE exit: error or store -> IDLE; legal load -> RESP, capturing mem_rdata into the winner's rdata register.
REQ-024 RESP (one cycle): winner's rvalid = 1, rdata = the captured word; next state IDLE.
REQ-025 Latency: request seen in IDLE at cycle T -> gnt at T+1, store committed at end of T+1, rvalid at T+2.
REQ-026 Minimum spacing between accepted commands: 2 cycles (store/error), 3 cycles (load).
REQ-027 Requesters drop req or present a new command in the cycle after gnt; req is ignored outside IDLE.
REQ-028 Byte enables: word 1111; half 0011 if addr[1]=0, else 1100; byte 0001 shifted left by addr[1:0].
REQ-029 mem_wdata: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
REQ-030 Error: op=11, word with addr[1:0]!=0, half with addr[0]=1, or addr[31:2] >= MEM_WORDS; error gives gnt+err, no mem_we, no rvalid.
REQ-031 mem_be = 0000 and mem_we = 0 in IDLE and RESP; rdata holds its last value between loads.

Reset
REQ-032 reset takes priority over all activity: state IDLE, last-grant pointer = port 1 (port 0 wins the first tie), latches and rdata cleared.
REQ-033 All outputs 0 in any cycle where reset = 1; mem_we is gated by !reset, so a reset in ISSUE commits no write.
REQ-034 A command interrupted by reset gets no gnt and no rvalid; the requester re-issues it.

Structure
REQ-035 Shared package dm_arb_pkg holds the op encodings (OP_WORD, OP_BYTE, OP_HALF), the FSM state enum and the MEM_WORDS default.
REQ-036 One sub-module dm_lane_gen (combinational: op, addr, wdata -> be, replicated wdata, err) is instantiated once on the latched command.

Verification
REQ-037 p0 word store addr 0x10 data 0xDEADBEEF, then load -> gnt T+1, mem_be 1111, p0_rvalid T+2, p0_rdata 0xDEADBEEF.
REQ-038 p1 byte store addr 0x13 data 0x000000AB -> mem_be 1000, mem_wdata 0xABABABAB, mem_addr 0x10.
REQ-039 p0 and p1 both request every cycle -> grants alternate p0, p1, p0, ...; first grant goes to p0 after reset.
REQ-040 p0 half store addr 0x21, word load addr 0x2E, load addr 0x3000 -> each gnt+err, mem_we never 1, no rvalid.
REQ-041 reset asserted in the ISSUE cycle of a p0 store -> mem_we 0, no p0_gnt, memory unchanged, FSM IDLE next cycle.
